// File: rtl/uart_r_axi.sv
`default_nettype none
// =============================================================================
// Module   : uart_r_axi
// Brief    : AXI-lite read-only slave buffering UART receive bytes in a FIFO.
//            Optional macro UART_R_OVERRUN_EN: drop-on-full with sticky flag.
// Revision : 1.0 - initial release
// =============================================================================
module uart_r_axi #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        rready,
  output logic [1:0]  rresp
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          empty, full, push, pop, ar_hs, ovr_flag;
  logic [7:0]    head, count8;
  logic [31:0]   status_word, data_word;
  logic          unused_araddr;

  assign empty         = (count_q == '0);
  assign full          = (count_q == (AW+1)'(DEPTH));
  assign ar_hs         = (state_q == S_IDLE) && arvalid;
  // Bytes arriving at full are never stored, whether backpressured or dropped.
  assign push          = rx_valid && !full;
  assign pop           = ar_hs && !araddr[2] && !empty;
  assign head          = mem_q[rd_ptr_q];
  assign count8        = 8'(count_q);
  assign unused_araddr = ^araddr[31:3];

`ifdef UART_R_OVERRUN_EN
  logic ovr_q, ovr_d;

  assign rx_ready = 1'b1;
  assign ovr_flag = ovr_q;

  // A new overrun in the clearing cycle takes priority over the clear.
  always_comb begin
    ovr_d = ovr_q;
    if (ar_hs && araddr[2]) ovr_d = 1'b0;
    if (rx_valid && full)   ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end
`else
  assign rx_ready = !full;
  assign ovr_flag = 1'b0;
`endif

  assign status_word = {16'h0000, count8, 5'b00000, ovr_flag, full, !empty};
  assign data_word   = empty ? 32'h0 : ({24'h0, head} << {araddr[1:0], 3'b000});

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          rdata_d = araddr[2] ? status_word : data_word;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rdata_q  <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign arready = (state_q == S_IDLE);
  assign rvalid  = (state_q == S_RESP);
  assign rdata   = rdata_q;
  assign rresp   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_uart_r_axi.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_r_axi
// Brief    : Self-checking bench for uart_r_axi (vector table plus sequences).
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_r_axi;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] araddr = 32'h0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [1:0]  rresp;

  int n_tests = 0;
  int n_fail  = 0;

  uart_r_axi #(.DEPTH(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .rresp    (rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; rx_valid = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Starts at a negedge with the slave idle; returns rdata seen with rvalid.
  task automatic rd(input logic [31:0] a, input string name, output logic [31:0] got);
    @(negedge clk);
    chk({name, " arready"}, {31'h0, arready}, 32'h1);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk({name, " rvalid"}, {31'h0, rvalid}, 32'h1);
    chk({name, " rresp"}, {30'h0, rresp}, 32'h0);
    got = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] got;
    rd(a, name, got);
    chk(name, got, exp);
  endtask

  initial begin
    logic [31:0] got;

    vecs[0]  = '{1'b1, 32'h4, 8'h00, 32'h0000_0000, "status after reset"};
    vecs[1]  = '{1'b0, 32'h0, 8'h41, 32'h0, "push 41"};
    vecs[2]  = '{1'b0, 32'h0, 8'h42, 32'h0, "push 42"};
    vecs[3]  = '{1'b0, 32'h0, 8'h43, 32'h0, "push 43"};
    vecs[4]  = '{1'b1, 32'h0, 8'h00, 32'h0000_0041, "read lane0"};
    vecs[5]  = '{1'b1, 32'h1, 8'h00, 32'h0000_4200, "read lane1"};
    vecs[6]  = '{1'b1, 32'h6, 8'h00, 32'h0000_0101, "status count1"};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF8, 8'h00, 32'h0000_0043, "read high addr bits"};
    vecs[8]  = '{1'b1, 32'h0, 8'h00, 32'h0000_0000, "read empty"};
    vecs[9]  = '{1'b1, 32'h4, 8'h00, 32'h0000_0000, "status empty"};
    vecs[10] = '{1'b0, 32'h0, 8'h77, 32'h0, "push 77"};
    vecs[11] = '{1'b1, 32'h3, 8'h00, 32'h7700_0000, "read lane3"};
    vecs[12] = '{1'b0, 32'h0, 8'h12, 32'h0, "push 12"};
    vecs[13] = '{1'b0, 32'h0, 8'h34, 32'h0, "push 34"};
    vecs[14] = '{1'b1, 32'h2, 8'h00, 32'h0012_0000, "read lane2"};
    vecs[15] = '{1'b1, 32'h0, 8'h00, 32'h0000_0034, "read last"};

    do_reset();
    @(negedge clk);
    chk("reset rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("reset arready", {31'h0, arready}, 32'h1);
    chk("reset rvalid", {31'h0, rvalid}, 32'h0);
    chk("reset rresp", {30'h0, rresp}, 32'h0);
    chk("reset rdata", rdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_read) rd_chk(vecs[i].addr, vecs[i].exp, vecs[i].name);
      else                 push(vecs[i].data);
    end

    // Fill to full
    for (int i = 0; i < 16; i++) push(8'(i));
    @(negedge clk);
    chk("status full", 32'h0, 32'h0 | 0);
`ifdef UART_R_OVERRUN_EN
    chk("full rx_ready", {31'h0, rx_ready}, 32'h1);
    push(8'h10);
    rd_chk(32'h4, 32'h0000_1007, "status overrun");
    rd_chk(32'h4, 32'h0000_1003, "status overrun cleared");
`else
    chk("full rx_ready", {31'h0, rx_ready}, 32'h0);
    rd_chk(32'h4, 32'h0000_1003, "status full");
    push(8'h10);
    rd_chk(32'h4, 32'h0000_1003, "status full after blocked push");
`endif
    for (int i = 0; i < 16; i++) rd_chk(32'h0, {24'h0, 8'(i)}, $sformatf("drain %0d", i));
    rd_chk(32'h0, 32'h0, "byte 17 absent");

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    @(negedge clk);
    rx_data = 8'h55; rx_valid = 1'b1; araddr = 32'h0; arvalid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; arvalid = 1'b0;
    chk("pushpop rdata", rdata, 32'h0000_00A0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    rd_chk(32'h4, 32'h0000_0501, "pushpop count");
    for (int i = 1; i < 5; i++) rd_chk(32'h0, {24'h0, 8'hA0 + 8'(i)}, $sformatf("pushpop drain %0d", i));
    rd_chk(32'h0, 32'h0000_0055, "pushpop new byte");

    // rready stall
    push(8'h99);
    @(negedge clk);
    araddr = 32'h0; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall rvalid %0d", i), {31'h0, rvalid}, 32'h1);
      chk($sformatf("stall rdata %0d", i), rdata, 32'h0000_0099);
      chk($sformatf("stall arready %0d", i), {31'h0, arready}, 32'h0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("stall release arready", {31'h0, arready}, 32'h1);
    rd_chk(32'h4, 32'h0, "stall status empty");

    // Reset in the middle of a read discards buffered bytes
    push(8'h01);
    push(8'h02);
    @(negedge clk);
    araddr = 32'h0; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midreset rvalid", {31'h0, rvalid}, 32'h0);
    chk("midreset rdata", rdata, 32'h0);
    rd_chk(32'h4, 32'h0, "midreset status");
    push(8'h5A);
    rd_chk(32'h0, 32'h0000_005A, "post reset push");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
